// File: rtl/shared_dff_arbiter_if.sv
// rtl/shared_dff_arbiter_if.sv - requester-side bus for the shared q/qb register arbiter
// The lock signal exists only when SHARED_DFF_LOCK_EN is defined.
interface shared_dff_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) ();
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic                  clr;
`ifdef SHARED_DFF_LOCK_EN
    logic [NREQ-1:0]       lock;
`endif
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      qb;
    logic                  busy;

`ifdef SHARED_DFF_LOCK_EN
    modport master (output req, wdata, clr, lock, input gnt, ack, q, qb, busy);
    modport slave  (input req, wdata, clr, lock, output gnt, ack, q, qb, busy);
`else
    modport master (output req, wdata, clr, input gnt, ack, q, qb, busy);
    modport slave  (input req, wdata, clr, output gnt, ack, q, qb, busy);
`endif
endinterface

// File: rtl/shared_dff_arbiter.sv
// rtl/shared_dff_arbiter.sv - round-robin write arbiter and sequencer for one shared q/qb register
// Optional owner lock (back-to-back writes up to MAX_LOCK) is enabled by SHARED_DFF_LOCK_EN.
module shared_dff_arbiter #(
    parameter int               NREQ     = 4,
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter int               MAX_LOCK = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    shared_dff_arbiter_if.slave  bus
);
    localparam int              PW     = $clog2(NREQ);
    localparam logic [PW:0]     NREQ_W = NREQ[PW:0];
    localparam logic [PW-1:0]   LAST   = PW'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

    state_t           state, state_nxt;
    logic [NREQ-1:0]  gnt_r, gnt_nxt;
    logic [NREQ-1:0]  ack_r, ack_nxt;
    logic [WIDTH-1:0] q_r, q_nxt;
    logic [PW-1:0]    ptr, ptr_nxt;
    logic [PW-1:0]    owner, owner_nxt;
    logic [PW-1:0]    win;
    logic [PW:0]      sum;
    logic             found;
`ifdef SHARED_DFF_LOCK_EN
    localparam int            CW         = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] MAX_LOCK_W = CW'(MAX_LOCK);
    logic [CW-1:0]    cnt, cnt_nxt;
`endif

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_r;
        ack_nxt   = '0;
        q_nxt     = q_r;
        ptr_nxt   = ptr;
        owner_nxt = owner;
`ifdef SHARED_DFF_LOCK_EN
        cnt_nxt   = cnt;
`endif
        win       = ptr;
        found     = 1'b0;
        sum       = '0;

        // First requester at or above the pointer, wrapping modulo NREQ
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + k[PW:0];
            if (sum >= NREQ_W) sum = sum - NREQ_W;
            if (!found && bus.req[sum[PW-1:0]]) begin
                found = 1'b1;
                win   = sum[PW-1:0];
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt      = '0;
                    gnt_nxt[win] = 1'b1;
                    owner_nxt    = win;
`ifdef SHARED_DFF_LOCK_EN
                    cnt_nxt      = '0;
`endif
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
                if (!bus.clr && bus.req[owner]) begin
                    q_nxt          = bus.wdata[owner*WIDTH +: WIDTH];
                    ack_nxt[owner] = 1'b1;
                    ptr_nxt        = (owner == LAST) ? '0 : owner + 1'b1;
`ifdef SHARED_DFF_LOCK_EN
                    cnt_nxt        = cnt + 1'b1;
`endif
                    state_nxt      = ACK;
                end
            end
            ACK: begin
                state_nxt = IDLE;
`ifdef SHARED_DFF_LOCK_EN
                // Locked owner re-enters GRANT directly; ptr already points past it for resumption
                if (bus.req[owner] && bus.lock[owner] && cnt < MAX_LOCK_W) begin
                    gnt_nxt[owner] = 1'b1;
                    state_nxt      = GRANT;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase

        if (bus.clr) q_nxt = RST_VAL;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            gnt_r <= '0;
            ack_r <= '0;
            q_r   <= RST_VAL;
            ptr   <= '0;
            owner <= '0;
`ifdef SHARED_DFF_LOCK_EN
            cnt   <= '0;
`endif
        end else begin
            state <= state_nxt;
            gnt_r <= gnt_nxt;
            ack_r <= ack_nxt;
            q_r   <= q_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
`ifdef SHARED_DFF_LOCK_EN
            cnt   <= cnt_nxt;
`endif
        end
    end

    assign bus.gnt  = gnt_r;
    assign bus.ack  = ack_r;
    assign bus.q    = q_r;
    assign bus.qb   = ~q_r;
    assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_shared_dff_arbiter.sv
// tb/tb_shared_dff_arbiter.sv - directed bench for shared_dff_arbiter (lock steps under SHARED_DFF_LOCK_EN)
module tb_shared_dff_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   vecs = 0;
    int   miss = 0;
    int   w;

    always #5 clk = ~clk;

    shared_dff_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

    shared_dff_arbiter #(
        .NREQ(4), .WIDTH(8), .RST_VAL(8'h00), .MAX_LOCK(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vecs++;
        assert (obs === exp_v) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        reset     = 1'b0;
        bus.req   = '0;
        bus.wdata = '0;
        bus.clr   = 1'b0;
`ifdef SHARED_DFF_LOCK_EN
        bus.lock  = '0;
`endif
        tick();
        chk("rst_q",  32'(bus.q),  32'h00);
        chk("rst_qb", 32'(bus.qb), 32'hFF);
        chk("rst_ctl", 32'({bus.gnt, bus.ack, bus.busy}), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_q",   32'(bus.q),  32'h00);
            chk("idle_qb",  32'(bus.qb), 32'hFF);
            chk("idle_ctl", 32'({bus.gnt, bus.ack, bus.busy}), 32'h0);
        end

        bus.wdata[2*8 +: 8] = 8'hA5;
        bus.req = 4'b0100;
        tick();
        chk("one_gnt",  32'(bus.gnt),  32'b0100);
        chk("one_ack0", 32'(bus.ack),  32'b0000);
        chk("one_busy", 32'(bus.busy), 32'h1);
        tick();
        chk("one_ack",  32'(bus.ack), 32'b0100);
        chk("one_q",    32'(bus.q),   32'hA5);
        chk("one_qb",   32'(bus.qb),  32'h5A);
        chk("one_gntc", 32'(bus.gnt), 32'b0000);
        bus.req = '0;
        tick();
        chk("one_done", 32'({bus.ack, bus.busy}), 32'h0);

        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.wdata = 32'h44332211;
        bus.req   = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            w = i % 4;
            tick();
            chk("rr_gnt", 32'(bus.gnt), 32'(4'b0001 << w));
            tick();
            chk("rr_ack", 32'(bus.ack), 32'(4'b0001 << w));
            chk("rr_q",   32'(bus.q),   32'(8'h11 * (w + 1)));
            if (i == 4) bus.req = '0;
            tick();
            chk("rr_ackc", 32'(bus.ack), 32'h0);
        end

        bus.req = 4'b0010;
        tick();
        chk("abort_gnt", 32'(bus.gnt), 32'b0010);
        bus.req = '0;
        tick();
        chk("abort_ack",  32'(bus.ack),  32'h0);
        chk("abort_gnt0", 32'(bus.gnt),  32'h0);
        chk("abort_q",    32'(bus.q),    32'h11);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        bus.req = 4'b0011;
        tick();
        chk("abort_ptr", 32'(bus.gnt), 32'b0010);
        tick();
        chk("abort_ack1", 32'(bus.ack), 32'b0010);
        chk("abort_q1",   32'(bus.q),   32'h22);
        bus.req = '0;
        tick();

        bus.wdata[3*8 +: 8] = 8'h3C;
        bus.req = 4'b1000;
        tick();
        chk("clr_gnt", 32'(bus.gnt), 32'b1000);
        bus.clr = 1'b1;
        tick();
        chk("clr_q",    32'(bus.q),    32'h00);
        chk("clr_ack",  32'(bus.ack),  32'h0);
        chk("clr_busy", 32'(bus.busy), 32'h0);
        bus.clr = 1'b0;
        tick();
        chk("clr_regnt", 32'(bus.gnt), 32'b1000);
        tick();
        chk("clr_ack3", 32'(bus.ack), 32'b1000);
        chk("clr_q3",   32'(bus.q),   32'h3C);
        bus.req = 4'b0001;
        tick();
        tick();
        chk("arst_gnt", 32'(bus.gnt), 32'b0001);
        reset = 1'b0;
        #1;
        chk("arst_q",   32'(bus.q),  32'h00);
        chk("arst_qb",  32'(bus.qb), 32'hFF);
        chk("arst_ctl", 32'({bus.gnt, bus.ack, bus.busy}), 32'h0);
        bus.req = '0;
        tick();
        reset = 1'b1;
        tick();
        chk("arst_after", 32'({bus.gnt, bus.ack, bus.busy}), 32'h0);

`ifdef SHARED_DFF_LOCK_EN
        bus.wdata[0 +: 8] = 8'h5E;
        bus.req  = 4'b0011;
        bus.lock = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lock_gnt", 32'(bus.gnt), 32'b0001);
            tick();
            chk("lock_ack", 32'(bus.ack), 32'b0001);
        end
        tick();
        chk("lock_idle", 32'({bus.gnt, bus.busy}), 32'h0);
        tick();
        chk("lock_gnt1", 32'(bus.gnt), 32'b0010);
        tick();
        chk("lock_ack1", 32'(bus.ack), 32'b0010);
        bus.req  = '0;
        bus.lock = '0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
